// File: rtl/dmem_lsu.sv
// dmem_lsu: RV32I load/store unit that drives a word-addressed, byte-enable data RAM.
// Converts LB/LH/LW/LBU/LHU/SB/SH/SW into a RAM access with lane-placed data, then
// returns one response per request (sign/zero-extended load data, error flag).
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses are reported as errors
//   undefined -> misaligned accesses are forced aligned and proceed normally
module dmem_lsu #(
    parameter int unsigned MEM_LAT = 1  // RAM read latency in cycles, 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] daddr,
    output logic [31:0] indata,
    output logic [3:0]  we,
    input  logic [31:0] outdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] indata_q, indata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  we_q, we_d;
    logic        err_q, err_d;

    // Request decode results
    logic        f3_legal;
    logic        misaligned;
    logic        req_err;
    logic [1:0]  req_off;
    logic [3:0]  req_we;
    logic [31:0] req_data;

    // Load extraction results
    logic [31:0] lane_word;
    logic [31:0] load_val;

    // Decode the incoming request: funct3 legality, alignment, lane placement.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        req_off    = req_addr[1:0];
        misaligned = 1'b0;
        req_we     = 4'b0000;
        req_data   = req_wdata;

        if (req_store) f3_legal = (req_funct3 <= 3'd2);
        else           f3_legal = (req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});

        case (req_funct3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

`ifdef LSU_MISALIGN_TRAP_EN
        req_err = !f3_legal || misaligned;
`else
        req_err = !f3_legal;
        // Halfword drops addr[0]; word drops addr[1:0].
        if (misaligned) req_off = (req_funct3[1:0] == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
`endif

        case (req_funct3[1:0])
            2'b00: begin
                req_we   = 4'b0001 << req_off;
                req_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_we   = req_off[1] ? 4'b1100 : 4'b0011;
                req_data = {2{req_wdata[15:0]}};
            end
            default: begin
                req_we   = 4'b1111;
                req_data = req_wdata;
            end
        endcase

        if (!req_store) req_we = 4'b0000;
    end

    // Select the addressed lane of the RAM word and extend it by funct3.
    always_comb begin
        lane_word = outdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    load_val = {{24{lane_word[7]}}, lane_word[7:0]};
            3'd1:    load_val = {{16{lane_word[15]}}, lane_word[15:0]};
            3'd4:    load_val = {24'h0, lane_word[7:0]};
            3'd5:    load_val = {16'h0, lane_word[15:0]};
            default: load_val = lane_word;  // LW is always word aligned here
        endcase
    end

    // Next-state and handshake logic for the IDLE/ACCESS/WAIT/RESP sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        store_d  = store_q;
        f3_d     = f3_q;
        off_d    = off_q;
        daddr_d  = daddr_q;
        indata_d = indata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        we_d     = 4'b0000;  // write strobe lives for the single ACCESS cycle only

        req_ready  = (state_q == IDLE) || (state_q == RESP);
        resp_valid = (state_q == RESP);

        case (state_q)
            ACCESS: begin
                if (store_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = LAT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // A handshake in IDLE or RESP starts a new access (overrides RESP -> IDLE).
        if (req_valid && req_ready) begin
            store_d = req_store;
            f3_d    = req_funct3;
            off_d   = req_off;
            err_d   = req_err;
            if (req_err) begin
                state_d = RESP;  // no RAM access; daddr and indata keep their values
            end else begin
                state_d = ACCESS;
                daddr_d = {req_addr[31:2], 2'b00};
                we_d    = req_we;
                if (req_store) indata_d = req_data;
            end
        end
    end

    // State and datapath registers; all memory-side outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            store_q  <= 1'b0;
            f3_q     <= 3'd0;
            off_q    <= 2'b00;
            daddr_q  <= 32'h0;
            indata_q <= 32'h0;
            rdata_q  <= 32'h0;
            we_q     <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            store_q  <= store_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            daddr_q  <= daddr_d;
            indata_q <= indata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            err_q    <= err_d;
        end
    end

    assign daddr      = daddr_q;
    assign indata     = indata_q;
    assign we         = we_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
